// File: rtl/decode_execute_register.sv
// Decode-to-execute pipeline register with load-use bubble insertion, stall/flush
// handling and a saturating count of inserted bubbles.
module decode_execute_register #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_D,
    input  logic              regwBoolean_D,
    input  logic              memwBoolean_D,
    input  logic              MemrBoolean_D,
    input  logic              FlagW_D,
    input  logic [1:0]        ALUControl_D,
    input  logic [DATA_W-1:0] SrcA_D,
    input  logic [DATA_W-1:0] SrcB_D,
    input  logic [DATA_W-1:0] WriteData_D,
    input  logic [REG_W-1:0]  Rd_D,
    input  logic [REG_W-1:0]  Rs1_D,
    input  logic [REG_W-1:0]  Rs2_D,
    output logic              valid_E,
    output logic              regwBoolean_E,
    output logic              memwBoolean_E,
    output logic              MemrBoolean_E,
    output logic              FlagW_E,
    output logic [1:0]        ALUControl_E,
    output logic [DATA_W-1:0] SrcA_E,
    output logic [DATA_W-1:0] SrcB_E,
    output logic [DATA_W-1:0] WriteData_E,
    output logic [REG_W-1:0]  Rd_E,
    output logic [REG_W-1:0]  Rs1_E,
    output logic [REG_W-1:0]  Rs2_E,
    output logic              load_use_stall,
    output logic [CNT_W-1:0]  bubble_count
);

    logic              r_valid;
    logic              r_regw;
    logic              r_memw;
    logic              r_memr;
    logic              r_flagw;
    logic [1:0]        r_alu;
    logic [DATA_W-1:0] r_src_a;
    logic [DATA_W-1:0] r_src_b;
    logic [DATA_W-1:0] r_wdata;
    logic [REG_W-1:0]  r_rd;
    logic [REG_W-1:0]  r_rs1;
    logic [REG_W-1:0]  r_rs2;
    logic [CNT_W-1:0]  r_bubbles;

    logic w_load_use;
    logic w_cnt_sat;

    // No register-0 exemption: a load targeting r0 still stalls its consumer.
    assign w_load_use = r_valid & r_memr & valid_D &
                        ((r_rd == Rs1_D) | (r_rd == Rs2_D));
    assign w_cnt_sat  = &r_bubbles;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid   <= 1'b0;
            r_regw    <= 1'b0;
            r_memw    <= 1'b0;
            r_memr    <= 1'b0;
            r_flagw   <= 1'b0;
            r_alu     <= 2'b00;
            r_src_a   <= '0;
            r_src_b   <= '0;
            r_wdata   <= '0;
            r_rd      <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_bubbles <= '0;
        end else if (flush || (!stall && w_load_use)) begin
            r_valid   <= 1'b0;
            r_regw    <= 1'b0;
            r_memw    <= 1'b0;
            r_memr    <= 1'b0;
            r_flagw   <= 1'b0;
            r_alu     <= 2'b00;
            r_src_a   <= '0;
            r_src_b   <= '0;
            r_wdata   <= '0;
            r_rd      <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            // Only a genuine load-use bubble is counted; a flush wins without counting.
            if (!flush && !w_cnt_sat) begin
                r_bubbles <= r_bubbles + 1'b1;
            end
        end else if (!stall) begin
            r_valid   <= valid_D;
            r_regw    <= valid_D & regwBoolean_D;
            r_memw    <= valid_D & memwBoolean_D;
            r_memr    <= valid_D & MemrBoolean_D;
            r_flagw   <= valid_D & FlagW_D;
            r_alu     <= valid_D ? ALUControl_D : 2'b00;
            r_src_a   <= SrcA_D;
            r_src_b   <= SrcB_D;
            r_wdata   <= WriteData_D;
            r_rd      <= Rd_D;
            r_rs1     <= Rs1_D;
            r_rs2     <= Rs2_D;
        end
    end

    assign valid_E        = r_valid;
    assign regwBoolean_E  = r_regw;
    assign memwBoolean_E  = r_memw;
    assign MemrBoolean_E  = r_memr;
    assign FlagW_E        = r_flagw;
    assign ALUControl_E   = r_alu;
    assign SrcA_E         = r_src_a;
    assign SrcB_E         = r_src_b;
    assign WriteData_E    = r_wdata;
    assign Rd_E           = r_rd;
    assign Rs1_E          = r_rs1;
    assign Rs2_E          = r_rs2;
    assign load_use_stall = w_load_use;
    assign bubble_count   = r_bubbles;

endmodule
